serial_word_feeder: RTL and testbench
=====================================

Name: serial_word_feeder

Overview:
Parallel-to-serial front end that feeds one bit per clock into the serial pattern-detector stage (the Mealy "1101" detector input `i`). It accepts WIDTH-bit words over a valid/ready handshake and double-buffers them (shift register plus one holding register), so back-to-back words stream without gaps. When no word is pending it drives a constant idle bit.

Parameters:
WIDTH, 16, bits per word; legal range 2..64.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
IDLE_BIT, 0, value driven on serial_out while no word is being shifted.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
load_valid  in  1  upstream word available.
load_data  in  WIDTH  word to serialise; sampled only on handshake.
load_ready  out  1  block can accept a word this cycle.
serial_out  out  1  serial bit to the detector input.
serial_valid  out  1  high while serial_out carries a word bit (state SHIFT).
last_bit  out  1  high during the cycle the final bit of a word is on serial_out.
busy  out  1  high when in SHIFT or the holding register is full.

Behaviour:
- Reset, sampled on a clk edge while rst=1: state=IDLE, hold_full=0, bit_cnt=0, shift_reg=0. Outputs: load_ready=1, serial_out=IDLE_BIT, serial_valid=0, last_bit=0, busy=0.
- Handshake: a word is accepted on any rising edge where load_valid && load_ready.
  - load_ready = !hold_full and is driven from a register only. There is no combinational path from load_valid.
  - load_data must be held stable only in the accept cycle.
- States: IDLE and SHIFT.
  - IDLE, word accepted at edge k: the word loads directly into shift_reg, bit_cnt=0, state goes to SHIFT.
  - The first bit is on serial_out in the cycle after edge k. Latency from accept to first bit is 1 cycle.
  - IDLE, no accept: hold in IDLE.
- SHIFT: one bit is presented per cycle, with bit_cnt = 0..WIDTH-1.
  - Presented bit is shift_reg[WIDTH-1] when MSB_FIRST=1, otherwise shift_reg[0].
  - Each edge shifts the register toward the output end and increments bit_cnt.
  - last_bit = (state==SHIFT && bit_cnt==WIDTH-1).
- End of word, at the edge where last_bit=1:
  - If hold_full: hold_reg moves to shift_reg, hold_full clears, bit_cnt=0, and the state stays SHIFT. There is no gap cycle; bit 0 of word N+1 follows the last bit of word N.
  - Else if a word is accepted on the same edge: it loads directly into shift_reg (seamless, same as above).
  - Else: state goes to IDLE and serial_out=IDLE_BIT from the next cycle.
- Accept while in SHIFT: the word goes into hold_reg and hold_full sets. load_ready falls in the next cycle.
- Simultaneous drain and accept when hold_full=1: impossible by construction, because load_ready=0.
- A word is never dropped or duplicated. Output order equals accept order.
- Reset mid-word: any partial word and the held word are discarded. Outputs return to reset values from the cycle after the reset edge.
- bit_cnt width is $clog2(WIDTH). It never exceeds WIDTH-1.

Decomposition:
- Package serial_pkg:
  - feeder_state_t enum {IDLE, SHIFT}.
  - Helper function cnt_width(WIDTH) returning $clog2(WIDTH).
- One sub-module, bit_counter:
  - Parameterised modulo-WIDTH counter.
  - Inputs: clk, rst, clear, count_enable. Outputs: count, rollover_flag (asserted at WIDTH-1).
  - Reused by the downstream deserialiser.

Test Plan:
- Reset: rst=1 for 2 cycles with load_valid=1. Require load_ready=1, serial_out=0, serial_valid=0, busy=0, and no word accepted.
- Single word, WIDTH=16, MSB_FIRST=1, load_data=16'hD000, one-cycle valid pulse.
  - serial_out bits 1,1,0,1 then twelve 0s, serial_valid high for exactly 16 cycles starting 1 cycle after accept.
  - last_bit on cycle 16 only. The attached detector pulses o exactly once.
- Back-to-back words: load_valid held high with 16'hAAAA then 16'h0F0F.
  - 32 contiguous valid bits, no serial_valid gap.
  - load_ready low from the cycle after the second accept until the first word's last_bit edge.
- Hold full: issue 3 words, the third offered while hold_full=1.
  - Third word is accepted only after load_ready reasserts.
  - Output order and content match words 1, 2, 3.
- LSB_FIRST (MSB_FIRST=0), load_data=16'h000B: first four bits out are 1,1,0,1.
- Reset mid-word: assert rst after 5 bits of 16'hFFFF with a second word held.
  - Next cycle serial_out=0 and serial_valid=0. The held word is never emitted.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial word feeder and its counter.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } feeder_state_t;

    // Width of a counter that spans 0..width-1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/bit_counter.sv
// Modulo-WIDTH up counter with a registered terminal-count flag.
// Ports: clk, rst (sync, active-high), clear (force 0), count_enable (advance),
//        count (current value), rollover_flag (high while count == WIDTH-1).
module bit_counter
    import serial_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned CW    = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          count_enable,
    output logic [CW-1:0] count,
    output logic          rollover_flag
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_count;
    logic          r_rollover;
    logic [CW-1:0] w_count_next;

    // Clear wins over enable; wrap back to 0 after the terminal count.
    always_comb begin
        w_count_next = r_count;
        if (clear) begin
            w_count_next = '0;
        end else if (count_enable) begin
            w_count_next = (r_count == LAST) ? '0 : CW'(r_count + CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_rollover <= 1'b0;
        end else begin
            r_count    <= w_count_next;
            r_rollover <= (w_count_next == LAST);
        end
    end

    assign count         = r_count;
    assign rollover_flag = r_rollover;

endmodule

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: accepts WIDTH-bit words on valid/ready, keeps one
// word shifting and one waiting so consecutive words stream with no gap.
// Ports: clk, rst (sync, active-high), load_valid/load_data/load_ready (input
//        handshake), serial_out/serial_valid/last_bit (serial stream), busy.
module serial_word_feeder
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int unsigned   CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    feeder_state_t    r_state, w_state_next;
    logic [WIDTH-1:0] r_shift, w_shift_next, w_shifted;
    logic [WIDTH-1:0] r_hold, w_hold_next;
    logic             r_hold_full, w_hold_full_next;
    logic             w_load_shift;
    logic             w_accept;
    logic             w_last;
    logic [CW-1:0]    w_cnt, w_cnt_next;
    logic             w_rollover;

    logic r_load_ready, r_serial_out, r_serial_valid, r_last_bit, r_busy;

    bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clk          (clk),
        .rst          (rst),
        .clear        (w_load_shift),
        .count_enable (r_state == SHIFT),
        .count        (w_cnt),
        .rollover_flag(w_rollover)
    );

    assign w_accept  = load_valid && r_load_ready;
    assign w_last    = (r_state == SHIFT) && w_rollover;
    assign w_shifted = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};

    // Next state, datapath and next values of the registered outputs.
    always_comb begin
        w_state_next     = r_state;
        w_shift_next     = r_shift;
        w_hold_next      = r_hold;
        w_hold_full_next = r_hold_full;
        w_load_shift     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_shift_next = load_data;
                    w_load_shift = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    // Held word takes priority; an accept cannot coincide with it
                    // because load_ready is low while the holding register is full.
                    if (r_hold_full) begin
                        w_shift_next     = r_hold;
                        w_hold_full_next = 1'b0;
                        w_load_shift     = 1'b1;
                    end else if (w_accept) begin
                        w_shift_next = load_data;
                        w_load_shift = 1'b1;
                    end else begin
                        w_shift_next = w_shifted;
                        w_state_next = IDLE;
                    end
                end else begin
                    w_shift_next = w_shifted;
                    if (w_accept) begin
                        w_hold_next      = load_data;
                        w_hold_full_next = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        w_cnt_next = w_cnt;
        if (w_load_shift) begin
            w_cnt_next = '0;
        end else if (r_state == SHIFT) begin
            w_cnt_next = w_last ? '0 : CW'(w_cnt + CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_shift        <= '0;
            r_hold         <= '0;
            r_hold_full    <= 1'b0;
            r_load_ready   <= 1'b1;
            r_serial_out   <= IDLE_BIT;
            r_serial_valid <= 1'b0;
            r_last_bit     <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_shift        <= w_shift_next;
            r_hold         <= w_hold_next;
            r_hold_full    <= w_hold_full_next;
            r_load_ready   <= !w_hold_full_next;
            r_serial_out   <= (w_state_next == SHIFT)
                              ? (MSB_FIRST ? w_shift_next[WIDTH-1] : w_shift_next[0])
                              : IDLE_BIT;
            r_serial_valid <= (w_state_next == SHIFT);
            r_last_bit     <= (w_state_next == SHIFT) && (w_cnt_next == LAST);
            r_busy         <= (w_state_next == SHIFT) || w_hold_full_next;
        end
    end

    assign load_ready   = r_load_ready;
    assign serial_out   = r_serial_out;
    assign serial_valid = r_serial_valid;
    assign last_bit     = r_last_bit;
    assign busy         = r_busy;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboard bench for serial_word_feeder: an MSB-first and an LSB-first
// instance share the stimulus; each keeps a queue of accepted words and the
// monitor checks every serial bit against the word at the head of that queue.
module tb_serial_word_feeder;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         ld_rdy [2];
    logic         s_out  [2];
    logic         s_vld  [2];
    logic         lst    [2];
    logic         bsy    [2];

    logic [W-1:0] exp_q [2][$];
    int           bit_idx [2];
    int           checks   = 0;
    int           failures = 0;

    serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ld_rdy[0]), .serial_out(s_out[0]), .serial_valid(s_vld[0]),
        .last_bit(lst[0]), .busy(bsy[0])
    );

    serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ld_rdy[1]), .serial_out(s_out[1]), .serial_valid(s_vld[1]),
        .last_bit(lst[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: words leave the queue after their last bit has
    // been presented; accepted words enter it in handshake order.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                exp_q[u].delete();
                bit_idx[u] = 0;
            end else begin
                if (s_vld[u] && exp_q[u].size() > 0) begin
                    bit_idx[u]++;
                    if (bit_idx[u] == W) begin
                        void'(exp_q[u].pop_front());
                        bit_idx[u] = 0;
                    end
                end
                if (load_valid && ld_rdy[u]) exp_q[u].push_back(load_data);
            end
        end
    end

    // Monitor: compare every output against the model, mid-cycle.
    always @(negedge clk) begin
        logic [W-1:0] w;
        logic         exp_v;
        logic         b;
        string        nm;
        for (int u = 0; u < 2; u++) begin
            nm    = (u == 0) ? "msb" : "lsb";
            exp_v = (exp_q[u].size() > 0);
            chk({nm, " serial_valid"}, 64'(s_vld[u]), 64'(exp_v));
            chk({nm, " busy"}, 64'(bsy[u]), 64'(exp_v));
            chk({nm, " load_ready"}, 64'(ld_rdy[u]), 64'(exp_q[u].size() < 2));
            if (exp_v) begin
                w = exp_q[u][0];
                b = (u == 0) ? w[W-1-bit_idx[u]] : w[bit_idx[u]];
                chk({nm, " serial_out"}, 64'(s_out[u]), 64'(b));
                chk({nm, " last_bit"}, 64'(lst[u]), 64'(bit_idx[u] == W - 1));
            end else begin
                chk({nm, " idle serial_out"}, 64'(s_out[u]), 64'(1'b0));
                chk({nm, " idle last_bit"}, 64'(lst[u]), 64'(1'b0));
            end
        end
    end

    // Offer one word and hold it until the handshake completes (bounded).
    task automatic send(input logic [W-1:0] w);
        int   n   = 0;
        logic got = 1'b0;
        load_data  = w;
        load_valid = 1'b1;
        while (!got && n < 200) begin
            @(posedge clk);
            if (ld_rdy[0]) got = 1'b1;
            n++;
        end
        chk("send_handshake", 64'(got), 64'(1'b1));
        #1;
        load_valid = 1'b0;
        load_data  = W'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit_idx[0] = 0;
        bit_idx[1] = 0;
        // Reset with an upstream word offered: nothing may be accepted.
        rst        = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        load_valid = 1'b0;
        idle(2);

        // Single word.
        send(16'hD000);
        idle(20);

        // Back-to-back pair.
        send(16'hAAAA);
        send(16'h0F0F);
        idle(40);

        // Three words: the third waits for the holding register to drain.
        send(16'h1357);
        send(16'h2468);
        send(16'h9BDF);
        idle(60);

        // Distinct LSB-first pattern.
        send(16'h000B);
        idle(20);

        // Randomised words with random gaps.
        repeat (40) begin
            send(W'($urandom));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 20));
        end
        idle(60);

        // Reset in the middle of a word with a second word held.
        send(16'hFFFF);
        send(16'h5A5A);
        idle(3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(40);

        // Recovery after reset.
        send(16'hC3C3);
        idle(25);

        chk("msb drained", 64'(exp_q[0].size()), 64'(0));
        chk("lsb drained", 64'(exp_q[1].size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
